// File: rtl/csa_stim_checker_if.sv
// Adder operand/result bus between the stimulus checker (master) and the
// carry-select adder under test (slave).
interface csa_stim_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, output b, output cin, input sum, input cout);
  modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/csa_stim_checker.sv
// csa_stim_checker: exhaustive stimulus generator and result checker for a
// WIDTH-bit adder. Sweeps every {cin,a,b}, waits SETTLE_CYCLES for the adder
// to settle, compares {cout,sum} with a+b+cin and counts mismatches.
// Optional feature macro: FAIL_CAPTURE_EN adds fail_vec/fail_obs, which
// capture the first failing vector of a sweep and the value observed for it.
module csa_stim_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  csa_stim_checker_if.master   adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2*WIDTH:0]     vec_idx
`ifdef FAIL_CAPTURE_EN
  ,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_obs
`endif
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [VW-1:0] LAST_VEC = {VW{1'b1}};

  // A zero settle time would sample the adder in the same cycle its operands change.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("csa_stim_checker: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [VW-1:0]    vec_idx_q, vec_idx_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [WIDTH:0]   expected, observed;
  logic             mismatch;
`ifdef FAIL_CAPTURE_EN
  logic [VW-1:0]    fail_vec_q, fail_vec_d;
  logic [WIDTH:0]   fail_obs_q, fail_obs_d;
`endif

  // Reference result is built from the registered operands, not from vec_idx.
  assign expected = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign observed = {adder.cout, adder.sum};
  assign mismatch = (observed != expected);

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    vec_idx_d   = vec_idx_q;
    err_count_d = err_count_q;
    settle_d    = settle_q;
`ifdef FAIL_CAPTURE_EN
    fail_vec_d  = fail_vec_q;
    fail_obs_d  = fail_obs_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          vec_idx_d   = '0;
          err_count_d = '0;
`ifdef FAIL_CAPTURE_EN
          fail_vec_d  = '0;
          fail_obs_d  = '0;
`endif
        end
      end
      DRIVE: begin
        {cin_d, a_d, b_d} = vec_idx_q;
        settle_d          = CW'(SETTLE_CYCLES);
        state_d           = WAIT;
      end
      WAIT: begin
        if (settle_q <= CW'(1)) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
`ifdef FAIL_CAPTURE_EN
          // Only the first failure of a sweep is kept.
          if (err_count_q == 16'd0) begin
            fail_vec_d = {cin_q, a_q, b_q};
            fail_obs_d = observed;
          end
`endif
        end
        if (vec_idx_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_idx_d = vec_idx_q + VW'(1);
          state_d   = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
    // done/pass follow one cycle into DONE and drop on the restarting edge.
    done_d = (state_q == DONE) && !start;
    pass_d = (state_q == DONE) && !start && (err_count_q == 16'd0);
  end

  // State and output registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      vec_idx_q   <= '0;
      err_count_q <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
`ifdef FAIL_CAPTURE_EN
      fail_vec_q  <= '0;
      fail_obs_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      vec_idx_q   <= vec_idx_d;
      err_count_q <= err_count_d;
      settle_q    <= settle_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
`ifdef FAIL_CAPTURE_EN
      fail_vec_q  <= fail_vec_d;
      fail_obs_q  <= fail_obs_d;
`endif
    end
  end

  assign adder.a   = a_q;
  assign adder.b   = b_q;
  assign adder.cin = cin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;
`ifdef FAIL_CAPTURE_EN
  assign fail_vec  = fail_vec_q;
  assign fail_obs  = fail_obs_q;
`endif

endmodule
